// File: rtl/md_pkg.sv
// Shared opcodes and state encoding for the iterative
// multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MTHI  = 3'd6;
  localparam logic [2:0] MD_MADD  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_unit_iter_if.sv
// Request/result bundle between the EX stage and the
// multiply/divide unit.
interface md_unit_iter_if #(
  parameter int XLEN = 32
);
  logic [2:0]      op;
  logic [XLEN-1:0] d1;
  logic [XLEN-1:0] d2;
  logic            req;
  logic            start;
  logic            busy;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] hi;

  modport master (
    output op, d1, d2, req,
    input  start, busy, lo, hi
  );

  modport slave (
    input  op, d1, d2, req,
    output start, busy, lo, hi
  );
endinterface

// File: rtl/md_div_core.sv
// Unsigned restoring divider, one quotient bit per step.
// done flags the step that produces the final bit.
module md_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      // negative trial difference means restore
      if (diff[XLEN]) begin
        rem_d = rem_sh[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end else begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done      = step && (cnt_q == CW'(XLEN - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/md_unit_iter.sv
// EX-stage multiply/divide unit owning HI/LO.
// Define MD_MADD_EN to enable signed multiply-accumulate (op 7).
module md_unit_iter
  import md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 5
) (
  input  logic           clk,
  input  logic           reset,
  md_unit_iter_if.slave  md
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e         state_q, state_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
`ifdef MD_MADD_EN
  logic              madd_q, madd_d;
`endif

  logic              is_mul, is_div, sgn_m, sgn_d;
  logic              a_neg, b_neg, start_w;
  logic [2*XLEN-1:0] ext_a, ext_b, product;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   quo, rem;
  logic              div_done;

`ifdef MD_MADD_EN
  assign is_mul = (md.op == MD_MULT) || (md.op == MD_MULTU)
               || (md.op == MD_MADD);
  assign sgn_m  = (md.op == MD_MULT) || (md.op == MD_MADD);
`else
  assign is_mul = (md.op == MD_MULT) || (md.op == MD_MULTU);
  assign sgn_m  = (md.op == MD_MULT);
`endif
  assign is_div  = (md.op == MD_DIV) || (md.op == MD_DIVU);
  assign sgn_d   = (md.op == MD_DIV);
  assign start_w = (is_mul || is_div) && !busy_q && !md.req;

  assign ext_a   = sgn_m ? {{XLEN{md.d1[XLEN-1]}}, md.d1}
                         : {{XLEN{1'b0}}, md.d1};
  assign ext_b   = sgn_m ? {{XLEN{md.d2[XLEN-1]}}, md.d2}
                         : {{XLEN{1'b0}}, md.d2};
  assign product = ext_a * ext_b;

  assign a_neg = sgn_d && md.d1[XLEN-1];
  assign b_neg = sgn_d && md.d2[XLEN-1];
  assign mag_a = a_neg ? -md.d1 : md.d1;
  assign mag_b = b_neg ? -md.d2 : md.d2;

  md_div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (start_w && is_div),
    .step      (state_q == DIV),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    dvd_d   = dvd_q;
`ifdef MD_MADD_EN
    madd_d  = madd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_w && is_mul) begin
          prod_d  = product;
          cnt_d   = CW'(MUL_LAT - 1);
          busy_d  = 1'b1;
          state_d = MUL;
`ifdef MD_MADD_EN
          madd_d  = (md.op == MD_MADD);
`endif
        end else if (start_w && is_div) begin
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (md.d2 == '0);
          dvd_d   = md.d1;
          busy_d  = 1'b1;
          state_d = DIV;
        end else if (!md.req && md.op == MD_MTLO) begin
          lo_d = md.d1;
        end else if (!md.req && md.op == MD_MTHI) begin
          hi_d = md.d1;
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
`ifdef MD_MADD_EN
          if (madd_q) {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
          else        {hi_d, lo_d} = prod_q;
`else
          {hi_d, lo_d} = prod_q;
`endif
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV: begin
        if (div_done) state_d = FIX;
      end
      FIX: begin
        // divide by zero returns all-ones and the raw dividend
        if (dz_q) begin
          lo_d = '1;
          hi_d = dvd_q;
        end else begin
          lo_d = qneg_q ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      dvd_q   <= '0;
`ifdef MD_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      dvd_q   <= dvd_d;
`ifdef MD_MADD_EN
      madd_q  <= madd_d;
`endif
    end
  end

  assign md.start = start_w;
  assign md.busy  = busy_q;
  assign md.lo    = lo_q;
  assign md.hi    = hi_q;

endmodule

// File: tb/tb_md_unit_iter.sv
// Scoreboard bench for md_unit_iter: driver pushes expected HI/LO
// and latency, a negedge monitor pops on commit and compares.
module tb_md_unit_iter;
  import md_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = XLEN + 1;
`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_unit_iter_if #(.XLEN(XLEN)) mif ();

  md_unit_iter #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .md    (mif)
  );

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          exp_start = 1'b0;
  int          mbusy = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] cm_hi = '0, cm_lo = '0;
  int          bcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit starts(input logic [2:0] o);
    return (o inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})
        || (MADD_EN && o == MD_MADD);
  endfunction

  // Reference: architectural results from plain arithmetic
  function automatic exp_t model(input logic [2:0] o,
                                 input logic [31:0] a, b, h, l);
    exp_t        e;
    longint      sp;
    logic [63:0] p;
    int          q, r;
    e.hi = h; e.lo = l; e.lat = MUL_LAT;
    sp = longint'($signed(a)) * longint'($signed(b));
    case (o)
      MD_MULT:  begin p = sp; e.hi = p[63:32]; e.lo = p[31:0]; end
      MD_MULTU: begin
        p = 64'(a) * 64'(b);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_MADD:  begin
        p = {h, l} + sp;
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_DIV, MD_DIVU: begin
        e.lat = DIV_LAT;
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else if (o == MD_DIVU) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          e.lo = q; e.hi = r;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input logic [2:0] o, input logic [31:0] a, b,
                       input logic r);
    exp_t e;
    bit   st;
    mif.op = o; mif.d1 = a; mif.d2 = b; mif.req = r;
    st = starts(o) && mbusy == 0 && !r;
    exp_start = st;
    @(posedge clk);
    if (mbusy > 0) begin
      mbusy--;
    end else if (st) begin
      e = model(o, a, b, m_hi, m_lo);
      sb.push_back(e);
      m_hi = e.hi; m_lo = e.lo; mbusy = e.lat;
    end else if (!r && (o == MD_MTLO || o == MD_MTHI)) begin
      if (o == MD_MTLO) m_lo = a; else m_hi = a;
      e.hi = m_hi; e.lo = m_lo; e.lat = 0;
      sb.push_back(e);
    end
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    mif.op = MD_NONE; mif.d1 = '0; mif.d2 = '0; mif.req = 1'b0;
    exp_start = 1'b0;
    sb.delete();
    mbusy = 0; m_hi = '0; m_lo = '0;
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cm_hi = '0; cm_lo = '0; bcnt = 0;
    end else begin
      chk("start", 32'(mif.start), 32'(exp_start));
      if (mif.busy) begin
        bcnt++;
        chk("busy_pending", 32'(sb.size() > 0), 32'd1);
        chk("lo_hold", mif.lo, cm_lo);
        chk("hi_hold", mif.hi, cm_hi);
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("lo", mif.lo, e.lo);
        chk("hi", mif.hi, e.hi);
        chk("latency", 32'(bcnt), 32'(e.lat));
        cm_hi = e.hi; cm_lo = e.lo; bcnt = 0;
      end else begin
        chk("lo_idle", mif.lo, cm_lo);
        chk("hi_idle", mif.hi, cm_hi);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] o;
    mif.op = MD_NONE; mif.d1 = '0; mif.d2 = '0; mif.req = 1'b0;
    #2;
    do_reset(3);
    drive(MD_NONE, 0, 0, 0);
    drive(MD_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    repeat (MUL_LAT + 1) drive(MD_NONE, 0, 0, 0);
    drive(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    repeat (DIV_LAT) drive(MD_NONE, 0, 0, 0);
    drive(MD_DIVU, 32'd7, 32'd2, 0);
    repeat (DIV_LAT) drive(MD_NONE, 0, 0, 0);
    drive(MD_DIVU, 32'd1234, 32'd0, 0);
    repeat (DIV_LAT) drive(MD_NONE, 0, 0, 0);
    drive(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    repeat (DIV_LAT) drive(MD_NONE, 0, 0, 0);
    drive(MD_MULT, 32'd9, 32'd9, 1);
    drive(MD_NONE, 0, 0, 0);
    drive(MD_DIV, 32'd100, 32'hFFFF_FFFD, 0);
    repeat (5) drive(MD_NONE, 0, 0, 1);
    drive(MD_MTLO, 32'hDEAD_BEEF, 0, 0);
    drive(MD_MTHI, 32'hCAFE_F00D, 0, 1);
    repeat (DIV_LAT) drive(MD_NONE, 0, 0, 0);
    drive(MD_MTHI, 32'd5, 0, 0);
    drive(MD_NONE, 0, 0, 0);
    drive(MD_DIVU, 32'hFFFF_0000, 32'd3, 0);
    repeat (9) drive(MD_NONE, 0, 0, 0);
    do_reset(2);
    drive(MD_NONE, 0, 0, 0);
    drive(MD_MTLO, 32'd10, 0, 0);
    drive(MD_MTHI, 32'd0, 0, 0);
    drive(MD_MADD, 32'd3, 32'hFFFF_FFFC, 0);
    repeat (MUL_LAT + 1) drive(MD_NONE, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      o = 3'($urandom_range(0, 7));
      drive(o, rnd_val(), rnd_val(), $urandom_range(0, 99) < 15);
    end
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && mbusy == 0) break;
      drive(MD_NONE, 0, 0, 0);
    end
    @(negedge clk);
    #1;
    chk("drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit_iter.md
Name: md_unit_iter

Overview:
- Parametrised multiply/divide unit in the EX stage of the pipelined CPU.
- Owns the HI/LO registers. Accepts one operation per start and reports Busy to hazard control.
- Successor to the fixed-width, instant-result unit:
  - width is generic;
  - division is a true iterative restoring divider;
  - HI/LO are committed only on completion;
  - optional signed multiply-accumulate.

Parameters:
- XLEN, 32, operand/HI/LO width (even, >= 8).
- MUL_LAT, 5, Busy cycles for mult/multu/madd (>= 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 madd.
- d1  in  XLEN  rs operand / dividend / mtxx source.
- d2  in  XLEN  rt operand / divisor.
- req  in  1  exception/interrupt in flight; blocks new operations this cycle.
- start  out  1  combinational; op in 1..4 or 7, Busy=0 and req=0.
- busy  out  1  registered; operation in progress.
- lo  out  XLEN  LO register.
- hi  out  XLEN  HI register.

Behaviour:
- Reset: lo=0, hi=0, busy=0, state IDLE, counters 0. Reset mid-operation aborts the operation with no HI/LO write.
- States:
  - IDLE: accepts op when req=0.
  - MUL: count down MUL_LAT.
  - DIV: XLEN iterations, then FIX.
  - FIX: sign correction and commit.
- Op decode:
  - op 5/6 in IDLE with req=0: lo/hi <= d1 at that edge; no busy.
  - op 5/6 while busy: ignored. Pipeline stalls them.
- mult/multu/madd:
  - Full 2*XLEN product of the operands, signed or unsigned, is registered at the start edge.
  - busy high exactly MUL_LAT cycles.
  - {hi,lo} written on the edge where busy falls.
  - madd: {hi,lo} <= {hi,lo} + signed product, using hi/lo as they stand at the commit edge.
- div/divu:
  - Start edge latches operand magnitudes and sign flags. Signed: negate negative operands.
  - Restoring algorithm, one quotient bit per cycle for XLEN cycles, then 1 FIX cycle.
  - busy high exactly XLEN+1 cycles.
  - FIX: quotient negated if signs differ; remainder takes the dividend's sign.
  - lo <= quotient, hi <= remainder on the falling-busy edge.
- Divide by zero: same latency; lo <= all-ones, hi <= d1 as latched. Applies to signed and unsigned.
- Signed overflow (MIN / -1): lo = MIN, hi = 0. This is the natural result of magnitude arithmetic modulo 2^XLEN.
- Before commit, lo/hi hold their pre-operation values throughout busy. mflo/mfhi stall on busy|start.
- op changing while busy: ignored. Operands are latched at start only.
- req=1 at the start edge: operation not started, no state change.
- req during busy: no effect. The in-flight operation belongs to an older, committed instruction.
- Back-to-back: a new op may start on the first cycle with busy=0, i.e. the cycle after commit.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: op 7 performs signed multiply-accumulate as above; start asserts for op 7.
- Undefined: op 7 is a no-op. start=0, no busy, HI/LO unchanged; the accumulate adder is not synthesised.

Decomposition:
- Package md_pkg:
  - op code constants MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTLO, MD_MTHI, MD_MADD;
  - state encoding IDLE/MUL/DIV/FIX.
- Sub-module md_div_core:
  - iterative unsigned restoring divider with load/step;
  - outputs quotient, remainder, done.
- Top-level keeps sign handling, the multiplier, counters and HI/LO.

Test Plan:
1. XLEN=32, mult d1=-3, d2=7 → start=1, busy 5 cycles, then hi=FFFFFFFF, lo=FFFFFFEB; lo unchanged (0) during busy.
2. div d1=-7, d2=2 → busy 33 cycles, lo=FFFFFFFD, hi=FFFFFFFF. divu d1=7, d2=2 → lo=3, hi=1.
3. divu d1=1234, d2=0 → lo=FFFFFFFF, hi=000004D2. div 80000000 / FFFFFFFF → lo=80000000, hi=0.
4. req=1 with op=mult → start=0, busy=0, HI/LO unchanged. req asserted mid-div → result still commits.
5. mthi d1=5 at reset-free idle → hi=5 next edge. mtlo issued while busy → ignored. Reset at div cycle 10 → busy=0, hi=lo=0.
6. MD_MADD_EN defined: hi=0, lo=10, madd 3*(-4) → hi=FFFFFFFF, lo=FFFFFFFE. Macro undefined → op 7: start=0, HI/LO unchanged.
